// File: rtl/proc9_seq_pkg.sv
// Shared types and constants for the 9-bit processor instruction sequencer.
// Instruction words are IIIXXXYYY: opcode, destination register, source register.
package proc9_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_MEM_WAIT  = 4'd2,
        ST_DECODE    = 4'd3,
        ST_STEP_WAIT = 4'd4,
        ST_ISSUE     = 4'd5,
        ST_EXEC      = 4'd6,
        ST_HALTED    = 4'd7,
        ST_ERROR     = 4'd8
    } seq_state_t;

    localparam int INSTR_W = 9;

    localparam logic [2:0] OP_MV           = 3'b000;
    localparam logic [2:0] OP_MVI          = 3'b001;
    localparam logic [2:0] OP_ADD          = 3'b010;
    localparam logic [2:0] OP_SUB          = 3'b011;
    localparam logic [2:0] OP_HALT_DEFAULT = 3'b111;

    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int X_MSB  = 5;
    localparam int X_LSB  = 3;
    localparam int Y_MSB  = 2;
    localparam int Y_LSB  = 0;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/proc9_sequencer.sv
// Autonomous fetch/issue sequencer for the 9-bit processor: reads program words,
// presents them on DIN with a one-cycle run pulse, and waits for done.
module proc9_sequencer
    import proc9_seq_pkg::*;
#(
    parameter int          ADDR_W       = 5,
    parameter logic [2:0]  HALT_OP      = OP_HALT_DEFAULT,
    parameter int          DONE_TIMEOUT = 6
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                halt_req,
    input  logic                step_mode,
    input  logic                step,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [INSTR_W-1:0]  mem_data,
    output logic                proc_run,
    output logic [INSTR_W-1:0]  proc_din,
    input  logic                proc_done,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [15:0]         instr_count,
    output seq_state_t          seq_state
);

    // Handshake with the processor: proc_run is high for exactly the ISSUE cycle,
    // proc_din holds the instruction through ISSUE and EXEC, and proc_done is
    // sampled on every EXEC clock edge; there is no back-pressure in either direction.

    localparam int              TMO_W    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

    seq_state_t          state;
    seq_state_t          state_next;
    logic [INSTR_W-1:0]  instr_reg;
    logic [TMO_W-1:0]    tmo_cnt;

    logic load_start;
    logic retire;
    logic ir_load;
    logic tmo_inc;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_start = 1'b0;
        retire     = 1'b0;
        ir_load    = 1'b0;
        tmo_inc    = 1'b0;
        mem_rd     = 1'b0;
        proc_run   = 1'b0;
        unique case (state)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) begin
                    load_start = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // halt_req is checked before the read so a halted run leaves memory untouched
                if (halt_req) begin
                    state_next = ST_HALTED;
                end else begin
                    mem_rd     = 1'b1;
                    state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                ir_load    = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode_of(instr_reg) == HALT_OP) begin
                    state_next = ST_HALTED;
                end else if (step_mode) begin
                    state_next = ST_STEP_WAIT;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_STEP_WAIT: begin
                if (halt_req) begin
                    state_next = ST_HALTED;
                end else if (step) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                proc_run   = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                // halt_req is deliberately ignored here; it takes effect at the next FETCH
                if (proc_done) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ST_ERROR;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc          <= '0;
            instr_reg   <= '0;
            instr_count <= '0;
            tmo_cnt     <= '0;
        end else begin
            if (load_start) begin
                pc <= start_addr;
            end else if (retire) begin
                pc <= pc + 1'b1;
            end

            if (load_start) begin
                instr_count <= '0;
            end else if (retire && (instr_count != 16'hFFFF)) begin
                instr_count <= instr_count + 16'd1;
            end

            if (ir_load) begin
                instr_reg <= mem_data;
            end

            tmo_cnt <= tmo_inc ? tmo_cnt + 1'b1 : '0;
        end
    end

    // mvi drives DIN onto the processor bus during execution, so DIN stays valid through EXEC
    assign proc_din  = ((state == ST_ISSUE) || (state == ST_EXEC)) ? instr_reg : '0;
    assign mem_addr  = pc;
    assign busy      = (state == ST_FETCH) || (state == ST_MEM_WAIT) || (state == ST_DECODE) ||
                       (state == ST_STEP_WAIT) || (state == ST_ISSUE) || (state == ST_EXEC);
    assign halted    = (state == ST_HALTED);
    assign error     = (state == ST_ERROR);
    assign seq_state = state;

endmodule

// File: tb/tb_proc9_sequencer.sv
// Bench for proc9_sequencer with a 1-cycle ROM, a behavioural processor and a
// program-level reference model that predicts registers, pc, counts and timing.
module tb_proc9_sequencer;
    import proc9_seq_pkg::*;

    localparam int ADDR_W       = 5;
    localparam int DEPTH        = 32;
    localparam int DONE_TIMEOUT = 6;

    localparam logic [8:0] W_MVI_R0_5  = 9'b001000101;
    localparam logic [8:0] W_MVI_R1_3  = 9'b001001011;
    localparam logic [8:0] W_ADD_R0_R1 = 9'b010000001;
    localparam logic [8:0] W_HALT      = 9'b111000000;
    localparam logic [8:0] W_MVI_R2_7  = 9'b001010111;
    localparam logic [8:0] W_SUB_R2_R0 = 9'b011010000;
    localparam logic [8:0] W_MVI_R0_2  = 9'b001000010;
    localparam logic [8:0] W_MV_R3_R0  = 9'b000011000;

    logic              clock;
    logic              resetn;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              halt_req;
    logic              step_mode;
    logic              step;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [8:0]        mem_data;
    logic              proc_run;
    logic [8:0]        proc_din;
    logic              proc_done;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [15:0]       instr_count;
    seq_state_t        seq_state;

    proc9_sequencer #(.ADDR_W(ADDR_W), .HALT_OP(3'b111), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .start(start), .start_addr(start_addr),
        .halt_req(halt_req), .step_mode(step_mode), .step(step),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .proc_run(proc_run), .proc_din(proc_din), .proc_done(proc_done),
        .pc(pc), .busy(busy), .halted(halted), .error(error),
        .instr_count(instr_count), .seq_state(seq_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- environment: ROM and processor ----------------
    logic [8:0] rom [DEPTH];
    always @(posedge clock) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    logic [8:0] pr [8];
    logic [8:0] p_ir;
    logic [1:0] p_rem;
    logic       kill_done;

    assign proc_done = (p_rem == 2'd1) && !kill_done;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p_rem <= 2'd0;
            p_ir  <= 9'd0;
            for (int r = 0; r < 8; r++) pr[r] <= 9'd0;
        end else if (proc_run) begin
            p_ir  <= proc_din;
            p_rem <= (proc_din[8:6] == 3'b010 || proc_din[8:6] == 3'b011) ? 2'd3 : 2'd1;
        end else if (p_rem != 2'd0) begin
            p_rem <= p_rem - 2'd1;
            if (p_rem == 2'd1 && !kill_done) begin
                case (p_ir[8:6])
                    3'b000:  pr[p_ir[5:3]] <= pr[p_ir[2:0]];
                    3'b001:  pr[p_ir[5:3]] <= {6'd0, proc_din[2:0]};
                    3'b010:  pr[p_ir[5:3]] <= pr[p_ir[5:3]] + pr[p_ir[2:0]];
                    default: pr[p_ir[5:3]] <= pr[p_ir[5:3]] - pr[p_ir[2:0]];
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0]        ref_regs [8];
    logic [8:0]        exp_q [$];
    logic [ADDR_W-1:0] exp_addr_q [$];
    int exp_pc, exp_cnt, exp_cycles, exp_reads;

    // Walks the program as a list of words; limit>=0 models halt_req seen at the FETCH after that many instructions.
    task automatic ref_run(input int sa, input int limit);
        int addr;
        logic [8:0] w;
        logic [2:0] op, x, y;
        addr = sa;
        exp_cnt = 0; exp_cycles = 0; exp_reads = 0;
        for (int guard = 0; guard < 64; guard++) begin
            if (limit >= 0 && exp_cnt == limit) begin
                exp_cycles += 1;
                break;
            end
            w = rom[addr];
            exp_reads++;
            exp_cycles += 3;
            op = w[8:6]; x = w[5:3]; y = w[2:0];
            if (op == 3'b111) break;
            exp_q.push_back(w);
            exp_addr_q.push_back(ADDR_W'(addr));
            case (op)
                3'd0:    ref_regs[x] = ref_regs[y];
                3'd1:    ref_regs[x] = {6'd0, y};
                3'd2:    ref_regs[x] = ref_regs[x] + ref_regs[y];
                default: ref_regs[x] = ref_regs[x] - ref_regs[y];
            endcase
            exp_cycles += (op == 3'd2 || op == 3'd3) ? 4 : 2;
            exp_cnt++;
            addr = (addr + 1) % DEPTH;
        end
        exp_pc = addr;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int run_seen  = 0;
    int rd_seen   = 0;
    int cyc       = 0;
    int issue_cyc = 0;
    int exec_len  = 0;

    always @(negedge clock) begin
        cyc++;
        if (mem_rd) rd_seen++;
        if (proc_done) exec_len = cyc - issue_cyc;
        if (proc_run) begin
            run_seen++;
            issue_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("run_unexpected", 32'd1, 32'd0);
            end else begin
                check("run_word", proc_din, exp_q.pop_front());
                check("run_pc", pc, exp_addr_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int sa);
        @(negedge clock);
        start_addr = ADDR_W'(sa);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!(halted || error) && n < budget);
        check("run_finished", halted | error, 1);
    endtask

    task automatic wait_run_word(input logic [8:0] word, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(proc_run && proc_din == word) && n < budget);
        check("saw_issue", proc_run && (proc_din == word), 1);
    endtask

    task automatic check_regs();
        for (int r = 0; r < 8; r++) check($sformatf("reg%0d", r), pr[r], ref_regs[r]);
    endtask

    task automatic load_basic();
        rom[0] = W_MVI_R0_5;
        rom[1] = W_MVI_R1_3;
        rom[2] = W_ADD_R0_R1;
        rom[3] = W_HALT;
    endtask

    task automatic run_free(input int sa);
        int n, rd_base;
        rd_base = rd_seen;
        ref_run(sa, -1);
        pulse_start(sa);
        wait_end(300, n);
        check("cycles", n, exp_cycles);
        check("halted", halted, 1);
        check("error_low", error, 0);
        check("pc", pc, exp_pc);
        check("instr_count", instr_count, exp_cnt);
        check("mem_reads", rd_seen - rd_base, exp_reads);
        check("issues_left", exp_q.size(), 0);
        check_regs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, rd_base, run_base, sa, len;
        logic [8:0] w;

        resetn = 1'b0; start = 1'b0; start_addr = '0; halt_req = 1'b0;
        step_mode = 1'b0; step = 1'b0; kill_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = W_HALT;
        for (int r = 0; r < 8; r++) ref_regs[r] = 9'd0;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_count", instr_count, 0);
        check("rst_run", proc_run, 0);
        check("rst_din", proc_din, 0);
        check("rst_rd", mem_rd, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // straight-line program
        load_basic();
        run_free(0);
        check("r0_is_8", pr[0], 9'd8);
        check("add_exec_len", exec_len, 3);

        // preload R0=2, then wrap from address 31
        rom[10] = W_MVI_R0_2;
        rom[11] = W_HALT;
        run_free(10);
        rom[31] = W_MVI_R2_7;
        rom[0]  = W_SUB_R2_R0;
        rom[1]  = W_HALT;
        run_free(31);
        check("wrap_pc", pc, 1);
        check("r2_is_5", pr[2], 9'd5);

        // step mode: one run per step, stray steps during EXEC ignored
        load_basic();
        step_mode = 1'b1;
        ref_run(0, -1);
        run_base = run_seen;
        pulse_start(0);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(8, 14)) @(negedge clock);
            check("step_parked_runs", run_seen - run_base, i);
            check("step_parked_busy", busy, 1);
            check("step_parked_run_low", proc_run, 0);
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            @(negedge clock);
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            repeat (10) @(negedge clock);
            check("step_one_run", run_seen - run_base, i + 1);
            check("step_count", instr_count, i + 1);
        end
        repeat (4) @(negedge clock);
        check("step_halted", halted, 1);
        check("step_pc", pc, exp_pc);
        check("step_issues_left", exp_q.size(), 0);
        check_regs();
        step_mode = 1'b0;

        // halt_req during the first EXEC cycle of add
        load_basic();
        ref_run(0, 3);
        rd_base = rd_seen;
        pulse_start(0);
        wait_run_word(W_ADD_R0_R1, 60);
        @(negedge clock);
        halt_req = 1'b1;
        wait_end(40, n);
        halt_req = 1'b0;
        check("hreq_halted", halted, 1);
        check("hreq_pc", pc, exp_pc);
        check("hreq_count", instr_count, exp_cnt);
        check("hreq_reads", rd_seen - rd_base, exp_reads);
        check_regs();

        // watchdog on a missing done
        rom[5] = W_MV_R3_R0;
        rom[6] = W_HALT;
        kill_done = 1'b1;
        exp_q.push_back(W_MV_R3_R0);
        exp_addr_q.push_back(ADDR_W'(5));
        pulse_start(5);
        wait_end(60, n);
        check("wd_cycles", n, 4 + DONE_TIMEOUT);
        check("wd_error", error, 1);
        check("wd_halted", halted, 0);
        check("wd_busy", busy, 0);
        check("wd_pc", pc, 5);
        check("wd_count", instr_count, 0);
        check("wd_din", proc_din, 0);
        kill_done = 1'b0;
        ref_run(5, -1);
        pulse_start(5);
        check("wd_error_cleared", error, 0);
        wait_end(60, n);
        check("wd_rerun_halted", halted, 1);
        check("wd_rerun_pc", pc, exp_pc);
        check("wd_rerun_count", instr_count, exp_cnt);
        check_regs();

        // asynchronous reset in the middle of add
        load_basic();
        ref_run(0, 2);
        exp_q.push_back(W_ADD_R0_R1);
        exp_addr_q.push_back(ADDR_W'(2));
        pulse_start(0);
        wait_run_word(W_ADD_R0_R1, 60);
        @(negedge clock);
        check("arst_pre_count", instr_count, 2);
        check("arst_pre_din", proc_din, W_ADD_R0_R1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_run", proc_run, 0);
        check("arst_din", proc_din, 0);
        check("arst_pc", pc, 0);
        check("arst_count", instr_count, 0);
        check("arst_state", seq_state, ST_IDLE);
        check("arst_busy", busy, 0);
        for (int r = 0; r < 8; r++) ref_regs[r] = 9'd0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // randomized straight-line programs
        for (int t = 0; t < 6; t++) begin
            sa  = $urandom_range(0, DEPTH - 1);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                w[8:6] = 3'($urandom_range(0, 3));
                w[5:3] = 3'($urandom_range(0, 7));
                w[2:0] = 3'($urandom_range(0, 7));
                rom[(sa + j) % DEPTH] = w;
            end
            rom[(sa + len) % DEPTH] = W_HALT;
            run_free(sa);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
